axis_pattern_gen: RTL

AXIS_PATTERN_GEN -- requirements
Module: axis_pattern_gen

---
 rtl/axis_pattern_gen_pkg.sv | 20 ++
 rtl/axis_pattern_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_gen_pkg.sv
// Shared encodings for the AXI-Stream test pattern generator: FSM states and
// pattern-mode constants, used by both the RTL and its bench.
package axis_pattern_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_HRAMP   = 2'd1,
        MODE_VRAMP   = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_t;

    // Checkerboard squares are 8x8 pixels: the colour flips on bit 3 of x/y.
    localparam int CHECKER_BIT = 3;

endpackage

// File: rtl/axis_pattern_gen.sv
// Raster test-pattern source with a registered AXI-Stream master output.
// Handshake: a beat moves on a rising edge with tvalid && tready; tvalid never depends on tready.
module axis_pattern_gen
    import axis_pattern_gen_pkg::*;
#(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_RESO_WIDTH  = 10
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     fsync,
    input  logic [C_RESO_WIDTH-1:0]  m_width,
    input  logic [C_RESO_WIDTH-1:0]  m_height,
    input  logic [1:0]               mode,
    input  logic [C_PIXEL_WIDTH-1:0] color,
    output logic                     busy,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);

    localparam logic [C_RESO_WIDTH-1:0] RESO_ONE = C_RESO_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [C_RESO_WIDTH-1:0]  x_q, x_d, y_q, y_d;
    logic [C_RESO_WIDTH-1:0]  w_q, w_d, h_q, h_d;
    mode_t                    mode_q, mode_d;
    logic [C_PIXEL_WIDTH-1:0] color_q, color_d;
    logic                     pending_q, pending_d;
    logic                     tvalid_q, tvalid_d;
    logic [C_PIXEL_WIDTH-1:0] tdata_q, tdata_d;
    logic                     tuser_q, tuser_d;
    logic                     tlast_q, tlast_d;

    logic                     start_ok;
    logic                     line_end;
    logic                     frame_end;
    logic [C_RESO_WIDTH-1:0]  x_adv, y_adv;

    function automatic logic [C_PIXEL_WIDTH-1:0] pixel_at(
        input mode_t                     m,
        input logic [C_PIXEL_WIDTH-1:0]  c,
        input logic [C_RESO_WIDTH-1:0]   px,
        input logic [C_RESO_WIDTH-1:0]   py
    );
        logic [C_PIXEL_WIDTH-1:0] p;
        p = '0;
        case (m)
            MODE_SOLID:   p = c;
            MODE_HRAMP:   p = C_PIXEL_WIDTH'(px);
            MODE_VRAMP:   p = C_PIXEL_WIDTH'(py);
            MODE_CHECKER: p = (px[CHECKER_BIT] ^ py[CHECKER_BIT]) ? c : '0;
            default:      p = '0;
        endcase
        return p;
    endfunction

    assign busy          = (state_q == ST_RUN);
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;

    // x_q/y_q name the pixel held in the output register (or about to be loaded).
    always_comb begin
        start_ok  = (m_width != '0) && (m_height != '0);
        line_end  = (x_q == w_q - RESO_ONE);
        frame_end = line_end && (y_q == h_q - RESO_ONE);
        x_adv     = line_end ? '0 : x_q + RESO_ONE;
        y_adv     = line_end ? y_q + RESO_ONE : y_q;
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        w_d       = w_q;
        h_d       = h_q;
        mode_d    = mode_q;
        color_d   = color_q;
        pending_d = pending_q;
        tvalid_d  = tvalid_q;
        tdata_d   = tdata_q;
        tuser_d   = tuser_q;
        tlast_d   = tlast_q;

        case (state_q)
            ST_IDLE: begin
                if (fsync && start_ok) begin
                    state_d   = ST_RUN;
                    w_d       = m_width;
                    h_d       = m_height;
                    mode_d    = mode_t'(mode);
                    color_d   = color;
                    x_d       = '0;
                    y_d       = '0;
                    pending_d = 1'b0;
                end
            end

            ST_RUN: begin
                pending_d = pending_q | fsync;
                if (!tvalid_q) begin
                    tvalid_d = 1'b1;
                    tdata_d  = pixel_at(mode_q, color_q, x_q, y_q);
                    tuser_d  = (x_q == '0) && (y_q == '0);
                    tlast_d  = line_end;
                end else if (m_axis_tready) begin
                    if (!frame_end) begin
                        x_d     = x_adv;
                        y_d     = y_adv;
                        tdata_d = pixel_at(mode_q, color_q, x_adv, y_adv);
                        tuser_d = 1'b0;
                        tlast_d = (x_adv == w_q - RESO_ONE);
                    end else if (pending_q || fsync) begin
                        // Back-to-back frame: the last beat's fsync is consumed here too.
                        pending_d = 1'b0;
                        w_d       = m_width;
                        h_d       = m_height;
                        mode_d    = mode_t'(mode);
                        color_d   = color;
                        x_d       = '0;
                        y_d       = '0;
                        if (start_ok) begin
                            tdata_d = pixel_at(mode_t'(mode), color, '0, '0);
                            tuser_d = 1'b1;
                            tlast_d = (m_width == RESO_ONE);
                        end else begin
                            state_d  = ST_IDLE;
                            tvalid_d = 1'b0;
                            tdata_d  = '0;
                            tuser_d  = 1'b0;
                            tlast_d  = 1'b0;
                        end
                    end else begin
                        state_d  = ST_IDLE;
                        tvalid_d = 1'b0;
                        tdata_d  = '0;
                        tuser_d  = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            mode_q    <= MODE_SOLID;
            color_q   <= '0;
            pending_q <= 1'b0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tuser_q   <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            w_q       <= w_d;
            h_q       <= h_d;
            mode_q    <= mode_d;
            color_q   <= color_d;
            pending_q <= pending_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tuser_q   <= tuser_d;
            tlast_q   <= tlast_d;
        end
    end

endmodule
